// File: rtl/rot_cmd_fifo.sv
// First-word fall-through command buffer for the rotate unit: stores {sel, data, shift} triples.
// Define ROT_CMD_FIFO_STATS_EN to add the saturating accepted_cnt push counter.
module rot_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [31:0]      in_data,
  input  logic [4:0]       in_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sel,
  output logic [31:0]      out_data,
  output logic [4:0]       out_shift,
  output logic [LVL_W-1:0] level
`ifdef ROT_CMD_FIFO_STATS_EN
  ,
  output logic [15:0]      accepted_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        sel;
    logic [31:0] data;
    logic [4:0]  shift;
  } cmd_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;
  cmd_t             head;

  // Handshake decodes depend only on stored level, so out_ready never reaches in_ready.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign doPush    = in_valid && in_ready && !flush;
  assign doPop     = out_valid && out_ready && !flush;

  assign head      = mem[rdPtr];
  assign out_sel   = head.sel;
  assign out_data  = head.data;
  assign out_shift = head.shift;

  // NOTE: storage has no reset; level and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= '{sel: in_sel, data: in_data, shift: in_shift};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      if (doPush && !doPop)      level <= level + LVL_W'(1);
      else if (doPop && !doPush) level <= level - LVL_W'(1);
    end
  end

`ifdef ROT_CMD_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted_cnt <= '0;
    end else if (doPush && accepted_cnt != 16'hFFFF) begin
      accepted_cnt <= accepted_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/rot_cmd_fifo.md
ROT_CMD_FIFO -- requirements
Module: rot_cmd_fifo

Interface
REQ-001 Parameter: DEPTH, 4, number of buffered rotate commands; power of two, 2..16.
REQ-002 Parameter: LVL_W, $clog2(DEPTH)+1, width of the occupancy output.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: flush  input  1  synchronous discard of all buffered commands.
REQ-006 Port: in_valid  input  1  producer offers a command.
REQ-007 Port: in_ready  output  1  buffer can accept a command this cycle.
REQ-008 Port: in_sel  input  1  rotate direction (0 = left, 1 = right).
REQ-009 Port: in_data  input  32  word to rotate.
REQ-010 Port: in_shift  input  5  rotate amount, 0..31.
REQ-011 Port: out_valid  output  1  head command present for the downstream rotator.
REQ-012 Port: out_ready  input  1  downstream rotator consumes the head command.
REQ-013 Port: out_sel / out_data / out_shift  output  1/32/5  head command fields.
REQ-014 Port: level  output  LVL_W  current occupancy, 0..DEPTH.

Function
REQ-015 Push occurs at an edge where in_valid=1, in_ready=1 and flush=0.
REQ-016 Pop occurs at an edge where out_valid=1, out_ready=1 and flush=0.
REQ-017 in_ready shall be 1 exactly when level<DEPTH, with no combinational path from out_ready (no pass-through when full).
REQ-018 out_valid shall be 1 exactly when level>0; out_* fields shall be the oldest unpopped command, driven directly from storage (first-word fall-through).
REQ-019 Latency: a command pushed into an empty buffer at edge N appears on out_* with out_valid=1 in the cycle following edge N.
REQ-020 Order: commands pop in push order; each {sel, data, shift} triple is stored and returned unaltered.
REQ-021 Simultaneous push and pop: both take effect; level unchanged; legal at any level 1..DEPTH-1, and at level=DEPTH only the pop occurs.
REQ-022 Read/write pointers are DEPTH-modulo and wrap from DEPTH-1 to 0 with no gap.
REQ-023 out_* fields while out_valid=0 are don't-care; the bench shall not check them.
REQ-024 flush=1: at the next edge level becomes 0 and pointers return to 0, and any push or pop in that cycle is ignored (flush has priority).
REQ-025 Holding out_ready=1 with out_valid=0, or in_valid=1 with in_ready=0, shall have no effect.

Reset
REQ-026 rst_n=0 asynchronously forces level=0, pointers=0, out_valid=0, and in_ready=1 (DEPTH>0); storage contents need not be cleared.
REQ-027 Reset asserted mid-operation discards all buffered commands; the first edge after release behaves as from empty.

Configuration
REQ-028 Macro ROT_CMD_FIFO_STATS_EN: when defined, adds output port accepted_cnt [15:0]; it increments by 1 on every push and saturates at 16'hFFFF.
REQ-029 With ROT_CMD_FIFO_STATS_EN, accepted_cnt resets to 0 on rst_n=0 and is not cleared by flush.
REQ-030 Without ROT_CMD_FIFO_STATS_EN, the accepted_cnt port and its counter are absent; all other behaviour is identical.

Verification
REQ-031 Empty; push sel=0 data=32'hA5A5A5A5 shift=1 with out_ready=0 -> next cycle out_valid=1, out_data=A5A5A5A5, out_shift=1, out_sel=0, level=1.
REQ-032 out_ready=0; push 5 commands data=1,2,3,4,5 on consecutive cycles -> in_ready=0 after the 4th push, level=4, data=5 not accepted; then out_ready=1 -> pops 1,2,3,4 in order, level=0.
REQ-033 Level=2 (heads 1,2); push 3 while popping for 6 cycles continuously with DEPTH=4 -> level stays 2 and pop order is strictly ascending across pointer wrap.
REQ-034 Level=3, in_valid=1, out_ready=1, flush=1 for one cycle -> next cycle level=0, out_valid=0, in_ready=1, and the offered command is not stored.
REQ-035 Level=2; drive rst_n=0 between edges -> out_valid=0 and level=0 immediately, before the next edge; after release, push data=32'h0000_0001 -> data appears alone at the head.
REQ-036 With ROT_CMD_FIFO_STATS_EN, perform 65537 pushes (popping continuously) -> accepted_cnt=16'hFFFF; a flush leaves it at 16'hFFFF and rst_n=0 clears it to 0.
